mem_handle_responder: RTL
=========================

Name: mem_handle_responder

Overview:
- Memory-side responder for the mem_handle request/done protocol used by the FPU layer engines (linear forward/backward, etc.).
- Serves NUM_PORTS initiator handles with round-robin arbitration onto one single-port synchronous SRAM bank of DEPTH words.
- Returns read data and a one-cycle done pulse per serviced request.
- Sits between the layer engines and the on-chip scratch memory.

Parameters:
- NUM_PORTS, 4: number of mem_handle initiators served.
- DEPTH, 1024: SRAM words; valid addresses 0..DEPTH-1.
- DATA_W, 32: word width.
- ADDR_W, 32: ptr width as carried on mem_handle.
- RD_LAT, 1: SRAM read latency in cycles, range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- avail  in  NUM_PORTS  per-port request valid
- r_en  in  NUM_PORTS  per-port read request
- w_en  in  NUM_PORTS  per-port write request
- ptr  in  NUM_PORTS*ADDR_W  per-port word address, port i at [i*ADDR_W +: ADDR_W]
- data_store  in  NUM_PORTS*DATA_W  per-port write data
- data_load  out  NUM_PORTS*DATA_W  per-port read data
- done  out  NUM_PORTS  per-port completion pulse
- busy  out  1  FSM not in IDLE
- err  out  1  sticky error flag, cleared only by rst

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: done=0, data_load=0 (all ports), busy=0, err=0, round-robin pointer=0, FSM=IDLE.
  - SRAM contents are not reset.
  - Reset mid-transaction abandons it: no done, no write commit if still in IDLE/ARB.
- Request: port i is eligible when avail[i]=1 and (r_en[i] or w_en[i]). avail with neither enable set is ignored and does not set err.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any port is eligible, grant the first eligible port at or after rr_ptr (modulo NUM_PORTS). Register g, ptr, data_store and op, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: lasts RD_LAT cycles. On its first cycle, issue the SRAM read, or commit the write. Then go to RESP.
  - RESP: assert done[g]=1 for exactly this cycle. Read: data_load[g] = SRAM data. Set rr_ptr=g+1 mod NUM_PORTS. Return to IDLE.
- Latency: from the IDLE cycle that samples the request to the done cycle is RD_LAT+1 cycles. Back-to-back service costs RD_LAT+2 cycles per request.
- data_load[i] is valid in the done[i] cycle and held until the next read completes on port i. Writes do not alter data_load.
- done is never asserted on more than one port in a cycle, and never for two consecutive cycles on one port.
- Initiators drop avail on the edge that sees done. The IDLE cycle following RESP therefore sees avail low unless the initiator re-requests.
- A still-asserted request (initiator waiting on other handles) is simply re-served. Reads are idempotent; a repeated write rewrites the same value.
- Request inputs are sampled only in IDLE. Changes on a port during its own ACCESS/RESP are ignored for that transaction.
- r_en and w_en both set: perform the write and set err.
- ptr >= DEPTH (out of range):
  - Read returns 0.
  - Write is dropped.
  - done still pulses and err is set.
- Simultaneous requests: strict round-robin, so no port waits more than NUM_PORTS-1 grants.
- busy = (state != IDLE).

Test Plan:
- Single write then read, port 0, RD_LAT=1: write ptr=5, data_store=32'hDEADBEEF, then read ptr=5. Expect done[0] at cycle 2 after each request sample, data_load[0]=32'hDEADBEEF, err=0.
- Contention: ports 0–3 all request reads together, rr_ptr=0. Expect done order 0,1,2,3 at spacing RD_LAT+2 cycles. After a further grant to port 2, the next simultaneous round starts at port 3.
- Held request: port 1 keeps avail/r_en high for 10 cycles at ptr=7 (value 42). Expect repeated single-cycle done pulses, never adjacent, with data_load[1]=42 each time.
- Boundary: read ptr=1024 with DEPTH=1024. Expect done, data_load=0, err=1. A following write ptr=1023, value 9, then read back gives 9, and err stays 1.
- Conflict: r_en=w_en=1 on port 2, ptr=3, data 77. Expect write committed (later read gives 77) and err=1.
- Reset mid-op: assert rst during ACCESS of a read with RD_LAT=3. Expect immediate done=0, busy=0, data_load=0. After release, a new request completes normally and prior SRAM contents are intact.

Source files
------------

// File: rtl/mem_handle_responder_if.sv
// Bundle of the mem_handle request/done signals between the layer engines
// (master) and the scratch-memory responder (slave).
interface mem_handle_responder_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
);
    logic [NUM_PORTS-1:0]        avail;
    logic [NUM_PORTS-1:0]        r_en;
    logic [NUM_PORTS-1:0]        w_en;
    logic [NUM_PORTS*ADDR_W-1:0] ptr;
    logic [NUM_PORTS*DATA_W-1:0] data_store;
    logic [NUM_PORTS*DATA_W-1:0] data_load;
    logic [NUM_PORTS-1:0]        done;
    logic                        busy;
    logic                        err;

    modport master (
        output avail, r_en, w_en, ptr, data_store,
        input  data_load, done, busy, err
    );

    modport slave (
        input  avail, r_en, w_en, ptr, data_store,
        output data_load, done, busy, err
    );
endinterface

// File: rtl/mem_handle_responder.sv
// Round-robin responder serving NUM_PORTS mem_handle initiators from one
// single-port synchronous SRAM bank; one done pulse per serviced request.
module mem_handle_responder #(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 1024,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RD_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_handle_responder_if.slave bus
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t state_q, state_d;

    logic [NUM_PORTS-1:0] elig;
    logic                 any_req;
    logic [GW-1:0]        pick;
    logic [GW-1:0]        idx;
    logic [ADDR_W-1:0]    pick_ptr;
    logic [DATA_W-1:0]    pick_data;
    logic                 pick_r;
    logic                 pick_w;

    logic [GW-1:0]        rr_q;
    logic [GW-1:0]        gnt_q;
    logic                 op_rd_q;
    logic                 op_wr_q;
    logic                 op_oor_q;
    logic                 op_err_q;
    logic [MW-1:0]        op_addr_q;
    logic [DATA_W-1:0]    op_data_q;
    logic [CW-1:0]        cnt_q;
    logic                 err_q;
    logic [DATA_W-1:0]    held_q [NUM_PORTS];

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [DATA_W-1:0]    rd_q;
    logic                 first_access;
    logic                 mem_we;
    logic                 mem_re;
    logic [DATA_W-1:0]    resp_data;

    assign elig = bus.avail & (bus.r_en | bus.w_en);

    // Scan from the highest offset down so the port closest to rr_q wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        any_req = 1'b0;
        pick    = '0;
        idx     = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            idx = GW'((int'(rr_q) + k) % NUM_PORTS);
            if (elig[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    assign pick_ptr  = bus.ptr[int'(pick)*ADDR_W +: ADDR_W];
    assign pick_data = bus.data_store[int'(pick)*DATA_W +: DATA_W];
    assign pick_r    = bus.r_en[pick];
    assign pick_w    = bus.w_en[pick];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (cnt_q == CW'(RD_LAT - 1)) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q      <= '0;
            gnt_q     <= '0;
            op_rd_q   <= 1'b0;
            op_wr_q   <= 1'b0;
            op_oor_q  <= 1'b0;
            op_err_q  <= 1'b0;
            op_addr_q <= '0;
            op_data_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) held_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        gnt_q     <= pick;
                        op_wr_q   <= pick_w;
                        op_rd_q   <= pick_r & ~pick_w;
                        op_oor_q  <= (pick_ptr >= ADDR_W'(DEPTH));
                        op_err_q  <= (pick_r & pick_w) | (pick_ptr >= ADDR_W'(DEPTH));
                        op_addr_q <= pick_ptr[MW-1:0];
                        op_data_q <= pick_data;
                        cnt_q     <= '0;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (first_access && op_err_q) err_q <= 1'b1;
                end
                RESP: begin
                    rr_q <= (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;
                    if (op_rd_q) held_q[gnt_q] <= resp_data;
                end
                default: ;
            endcase
        end
    end

    assign first_access = (state_q == ACCESS) && (cnt_q == '0);
    assign mem_we       = first_access & op_wr_q & ~op_oor_q;
    assign mem_re       = first_access & op_rd_q & ~op_oor_q;

    // rd_q is the SRAM output register; it stays stable through the rest of
    // ACCESS because no other access can start before RESP.
    // NOTE: the SRAM array and its output register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[op_addr_q] <= op_data_q;
        if (mem_re) rd_q <= mem[op_addr_q];
    end

    assign resp_data = op_oor_q ? '0 : rd_q;

    always_comb begin
        bus.done      = '0;
        bus.data_load = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            bus.data_load[i*DATA_W +: DATA_W] = held_q[i];
        end
        if (state_q == RESP) begin
            bus.done[gnt_q] = 1'b1;
            if (op_rd_q) bus.data_load[int'(gnt_q)*DATA_W +: DATA_W] = resp_data;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.err  = err_q;

endmodule
